// File: rtl/adc_uart_frame_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_uart_frame_sched_if
//  Description : Bundle of the scheduler's streaming signals: the sample FIFO
//                read side, the valid/ready byte link to the UART transmitter,
//                and the enable/status lines.
//                  master : the frame scheduler
//                  slave  : the environment (FIFO, UART, control)
//  Signals     : en          streaming enable
//                fifo_empty  sample FIFO empty flag
//                fifo_rd_en  FIFO read strobe
//                fifo_dout   FIFO data, valid the cycle after fifo_rd_en
//                tx_data     byte to the UART transmitter
//                tx_valid    tx_data valid
//                tx_ready    UART accepts the byte
//                busy        scheduler not idle
//                frame_done  one-cycle pulse per completed frame
//                frame_cnt   completed-frame counter
//  Revision    : 1.0  initial release
// ============================================================================
interface adc_uart_frame_sched_if;
    logic        en;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    modport master (
        input  en, fifo_empty, fifo_dout, tx_ready,
        output fifo_rd_en, tx_data, tx_valid, busy, frame_done, frame_cnt
    );

    modport slave (
        output en, fifo_empty, fifo_dout, tx_ready,
        input  fifo_rd_en, tx_data, tx_valid, busy, frame_done, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/adc_uart_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : adc_uart_frame_sched
//  Description : Pops 16-bit ADC samples from a non-FWFT FIFO (1-cycle read
//                latency), splits each into two bytes MSB first and hands them
//                to the UART over a valid/ready byte link. Samples are grouped
//                into frames of WORDS_PER_FRAME words, optionally preceded by a
//                header byte and followed by GAP_CYCLES idle cycles.
//  Ports       : sys_clk  system clock, rising edge
//                rst      asynchronous active-low reset
//                bus      adc_uart_frame_sched_if.master (FIFO, TX, status)
//  Revision    : 1.0  initial release
// ============================================================================
module adc_uart_frame_sched #(
    parameter int unsigned HDR_EN          = 1,
    parameter logic [7:0]  HDR_BYTE        = 8'hA5,
    parameter int unsigned WORDS_PER_FRAME = 8,
    parameter int unsigned GAP_CYCLES      = 4
) (
    input  wire logic               sys_clk,
    input  wire logic               rst,
    adc_uart_frame_sched_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_RD      = 3'd2,
        S_LAT     = 3'd3,
        S_SEND_HI = 3'd4,
        S_SEND_LO = 3'd5,
        S_GAP     = 3'd6
    } state_t;

    localparam logic [15:0] c_LAST_IDX = 16'(WORDS_PER_FRAME - 1);
    localparam logic [7:0]  c_GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam bit          c_HDR_ON   = (HDR_EN != 0);
    localparam bit          c_GAP_ON   = (GAP_CYCLES != 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_word;
    logic [15:0] r_widx;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_gap;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_tx_data_nxt;
    logic        r_tx_valid;
    logic        w_tx_valid_nxt;
    logic        r_frame_done;
    logic        w_frame_end;
    logic        w_rd_en;

    // Last byte of the frame accepted by the UART this cycle
    assign w_frame_end = (r_state == S_SEND_LO) && bus.tx_ready && (r_widx == c_LAST_IDX);

    always_comb begin
        w_state_nxt    = r_state;
        w_rd_en        = 1'b0;
        w_tx_valid_nxt = 1'b0;
        w_tx_data_nxt  = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (bus.en && !bus.fifo_empty)
                    w_state_nxt = c_HDR_ON ? S_HDR : S_RD;
            end
            S_HDR: begin
                if (bus.tx_ready)
                    w_state_nxt = S_RD;
            end
            S_RD: begin
                // An empty FIFO mid-frame stalls here; the frame is never aborted
                if (!bus.fifo_empty) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_LAT;
                end
            end
            S_LAT: begin
                w_state_nxt = S_SEND_HI;
            end
            S_SEND_HI: begin
                if (bus.tx_ready)
                    w_state_nxt = S_SEND_LO;
            end
            S_SEND_LO: begin
                if (bus.tx_ready) begin
                    if (r_widx == c_LAST_IDX)
                        w_state_nxt = c_GAP_ON ? S_GAP : S_IDLE;
                    else
                        w_state_nxt = S_RD;
                end
            end
            S_GAP: begin
                if (r_gap == c_GAP_LAST)
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The TX register is loaded from the next state so tx_valid/tx_data
        // come straight from flops; a stalled state reloads the same byte.
        // Entering SEND_HI from LAT takes the high byte straight off the FIFO
        // bus because the word register is being written on the same edge.
        case (w_state_nxt)
            S_HDR: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = HDR_BYTE;
            end
            S_SEND_HI: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = (r_state == S_LAT) ? bus.fifo_dout[15:8] : r_word[15:8];
            end
            S_SEND_LO: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = r_word[7:0];
            end
            default: begin
                w_tx_valid_nxt = 1'b0;
                w_tx_data_nxt  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_word       <= 16'h0000;
            r_widx       <= 16'h0000;
            r_gap        <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_frame_done <= w_frame_end;

            if (r_state == S_LAT)
                r_word <= bus.fifo_dout;

            if (r_state == S_IDLE)
                r_widx <= 16'h0000;
            else if ((r_state == S_SEND_LO) && bus.tx_ready && (r_widx != c_LAST_IDX))
                r_widx <= r_widx + 16'd1;

            if (r_state == S_GAP)
                r_gap <= r_gap + 8'd1;
            else
                r_gap <= 8'h00;
        end
    end

    // Completed-frame counter, free-running 16-bit wrap
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst)
            r_frame_cnt <= 16'h0000;
        else if (w_frame_end)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.tx_data    = r_tx_data;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire
